regfile_mp: RTL and testbench

//  Parametrised multi-port general register file with write bypass and a pending-write scoreboard.

---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bundles the write, read and scoreboard-marking signals of regfile_mp.
// Latency: none (wires only).
// Backpressure: none; the consumer stalls itself on rbusy.
// Ports: master = ID/WB pipeline side, slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     pend_set;
  logic [ADDR_W-1:0]        pend_addr;

  modport master (
    output we, waddr, wdata, re, raddr, pend_set, pend_addr,
    input  rdata, rbusy
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, pend_set, pend_addr,
    output rdata, rbusy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: N-read / M-write register file with same-cycle write bypass and a pending-write busy scoreboard.
// Latency: reads are combinational; write-to-read 0 cycles with BYPASS=1, else 1; busy visible 1 cycle after pend_set.
// Backpressure: none; ID watches rbusy and stalls itself.
// Ports: clk, rst (synchronous, active-high); rf (slave): we/waddr/wdata write ports,
//   re/raddr -> rdata/rbusy read ports, pend_set/pend_addr marks a destination busy.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [NUM_WR-1:0] wr_ok;

  // A write to r0 is discarded entirely when r0 is hardwired.
  generate
    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
      assign wr_ok[k] = rf.we[k] &&
                        !(ZERO_REG != 0 && rf.waddr[k*ADDR_W +: ADDR_W] == '0);
    end
  endgenerate

  // Clears applied first, then the set: a new producer issued in the same
  // cycle an older one retires must keep the register busy.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_ok[k]) busy_nxt[rf.waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (rf.pend_set && !(ZERO_REG != 0 && rf.pend_addr == '0)) begin
      busy_nxt[rf.pend_addr] = 1'b1;
    end
  end

  // Ascending port order: the youngest port's write is the one that sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem  <= '{default: '0};
      busy <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_ok[k]) mem[rf.waddr[k*ADDR_W +: ADDR_W]] <= rf.wdata[k*DATA_W +: DATA_W];
      end
      busy <= busy_nxt;
    end
  end

  generate
    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              byp_hit;
      logic [DATA_W-1:0] byp_dat;
      logic [DATA_W-1:0] rd_dat;
      logic              rd_busy;

      assign ra = rf.raddr[r*ADDR_W +: ADDR_W];

      // Later matches overwrite earlier ones, so the youngest writer forwards.
      always_comb begin
        byp_hit = 1'b0;
        byp_dat = '0;
        if (BYPASS != 0) begin
          for (int k = 0; k < NUM_WR; k++) begin
            if (rf.we[k] && rf.waddr[k*ADDR_W +: ADDR_W] == ra) begin
              byp_hit = 1'b1;
              byp_dat = rf.wdata[k*DATA_W +: DATA_W];
            end
          end
        end
      end

      // A forwarded value is by definition the retiring result, so never busy.
      always_comb begin
        rd_dat  = '0;
        rd_busy = 1'b0;
        if (!rst && rf.re[r] && !(ZERO_REG != 0 && ra == '0)) begin
          if (byp_hit) begin
            rd_dat = byp_dat;
          end else begin
            rd_dat  = mem[ra];
            rd_busy = busy[ra];
          end
        end
      end

      assign rf.rdata[r*DATA_W +: DATA_W] = rd_dat;
      assign rf.rbusy[r]                  = rd_busy;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) b1 ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) b0 ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .ZERO_REG(1))
    dut_byp (.clk(clk), .rst(rst), .rf(b1));
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .ZERO_REG(1))
    dut_nob (.clk(clk), .rst(rst), .rf(b0));

  // Both instances see identical stimulus.
  assign b0.we        = b1.we;
  assign b0.waddr     = b1.waddr;
  assign b0.wdata     = b1.wdata;
  assign b0.re        = b1.re;
  assign b0.raddr     = b1.raddr;
  assign b0.pend_set  = b1.pend_set;
  assign b0.pend_addr = b1.pend_addr;

  typedef struct {
    logic          rst;
    logic [1:0]    we;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [1:0]    re;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic          ps;
    logic [AW-1:0] pa;
    logic [DW-1:0] e_rd0;
    logic [DW-1:0] e_rd1;
    logic [1:0]    e_bz;
    logic [DW-1:0] n_rd0;
    logic [DW-1:0] n_rd1;
    logic [1:0]    n_bz;
  } vec_t;

  typedef struct {
    logic [DW-1:0] e_rd0;
    logic [DW-1:0] e_rd1;
    logic [1:0]    e_bz;
    logic [DW-1:0] n_rd0;
    logic [DW-1:0] n_rd1;
    logic [1:0]    n_bz;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mk(
    input logic r, input logic [1:0] we,
    input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
    input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
    input logic [1:0] re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
    input logic ps, input logic [AW-1:0] pa,
    input logic [DW-1:0] erd0, input logic [DW-1:0] erd1, input logic [1:0] ebz,
    input logic [DW-1:0] nrd0, input logic [DW-1:0] nrd1, input logic [1:0] nbz);
    vec_t v;
    v.rst = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.ps = ps; v.pa = pa;
    v.e_rd0 = erd0; v.e_rd1 = erd1; v.e_bz = ebz;
    v.n_rd0 = nrd0; v.n_rd1 = nrd1; v.n_bz = nbz;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  // Drive on the falling edge, push the expectation, then compare mid-low-phase.
  task automatic step(input vec_t v, input int row);
    exp_t e;
    @(negedge clk);
    rst          = v.rst;
    b1.we        = v.we;
    b1.waddr     = {v.wa1, v.wa0};
    b1.wdata     = {v.wd1, v.wd0};
    b1.re        = v.re;
    b1.raddr     = {v.ra1, v.ra0};
    b1.pend_set  = v.ps;
    b1.pend_addr = v.pa;
    sb.push_back('{v.e_rd0, v.e_rd1, v.e_bz, v.n_rd0, v.n_rd1, v.n_bz});
    #2;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty step %0d", row);
    end else begin
      e = sb.pop_front();
      chk("byp_rdata0", row, b1.rdata[DW-1:0], e.e_rd0);
      chk("byp_rdata1", row, b1.rdata[2*DW-1:DW], e.e_rd1);
      chk("byp_rbusy", row, {30'b0, b1.rbusy}, {30'b0, e.e_bz});
      chk("nob_rdata0", row, b0.rdata[DW-1:0], e.n_rd0);
      chk("nob_rdata1", row, b0.rdata[2*DW-1:DW], e.n_rd1);
      chk("nob_rbusy", row, {30'b0, b0.rbusy}, {30'b0, e.n_bz});
    end
  endtask

  localparam logic [DW-1:0] Z = '0;
  localparam logic [AW-1:0] A0 = '0;

  initial begin
    rst = 1'b1;
    b1.we = '0; b1.waddr = '0; b1.wdata = '0; b1.re = '0; b1.raddr = '0;
    b1.pend_set = 1'b0; b1.pend_addr = '0;
    repeat (2) @(posedge clk);

    // reset holds outputs at zero and discards writes / pend_set
    tbl.push_back(mk(1'b1, 2'b11, 5'd5, 32'h1, 5'd5, 32'h2, 2'b11, 5'd5, 5'd5, 1'b1, 5'd5, Z, Z, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, 5'd5, 32'h1234, A0, Z, 2'b01, 5'd5, A0, 1'b0, A0, 32'h1234, Z, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b11, 5'd5, 5'd5, 1'b0, A0, 32'h1234, 32'h1234, 2'b00, 32'h1234, 32'h1234, 2'b00));
    tbl.push_back(mk(1'b1, 2'b01, 5'd6, 32'h77, A0, Z, 2'b11, 5'd5, 5'd6, 1'b1, 5'd6, Z, Z, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b11, 5'd5, 5'd6, 1'b0, A0, Z, Z, 2'b00, Z, Z, 2'b00));
    // dual write to r7: port 1 wins, and is what the bypass forwards
    tbl.push_back(mk(1'b0, 2'b11, 5'd7, 32'hAAAA, 5'd7, 32'h5555, 2'b11, 5'd7, 5'd5, 1'b0, A0, 32'h5555, Z, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b01, 5'd7, 5'd7, 1'b0, A0, 32'h5555, Z, 2'b00, 32'h5555, Z, 2'b00));
    // bypass vs stored value on r3
    tbl.push_back(mk(1'b0, 2'b01, 5'd3, 32'h0BEE, A0, Z, 2'b00, A0, A0, 1'b0, A0, Z, Z, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, 5'd3, 32'hDEAD, A0, Z, 2'b10, A0, 5'd3, 1'b0, A0, Z, 32'hDEAD, 2'b00, Z, 32'h0BEE, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b11, 5'd3, A0, 1'b0, A0, 32'hDEAD, Z, 2'b00, 32'hDEAD, Z, 2'b00));
    // r0 is hardwired: write and pend_set both ignored
    tbl.push_back(mk(1'b0, 2'b01, A0, 32'hFFFF, A0, Z, 2'b11, A0, A0, 1'b1, A0, Z, Z, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b01, A0, A0, 1'b0, A0, Z, Z, 2'b00, Z, Z, 2'b00));
    // scoreboard on r9: busy one cycle after pend_set, cleared by the write
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b01, 5'd9, A0, 1'b1, 5'd9, Z, Z, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b11, 5'd9, 5'd9, 1'b0, A0, Z, Z, 2'b11, Z, Z, 2'b11));
    tbl.push_back(mk(1'b0, 2'b10, A0, Z, 5'd9, 32'h42, 2'b11, 5'd9, 5'd9, 1'b0, A0, 32'h42, 32'h42, 2'b00, Z, Z, 2'b11));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b11, 5'd9, 5'd9, 1'b0, A0, 32'h42, 32'h42, 2'b00, 32'h42, 32'h42, 2'b00));
    // set/clear collision on r4: data updated, busy survives
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b00, A0, A0, 1'b1, 5'd4, Z, Z, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b01, 5'd4, 32'h44, A0, Z, 2'b11, 5'd4, 5'd4, 1'b1, 5'd4, 32'h44, 32'h44, 2'b00, Z, Z, 2'b11));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b11, 5'd4, 5'd4, 1'b0, A0, 32'h44, 32'h44, 2'b11, 32'h44, 32'h44, 2'b11));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b01, 5'd4, A0, 1'b1, 5'd4, 32'h44, Z, 2'b01, 32'h44, Z, 2'b01));
    // reset mid-operation wipes data and pending bits
    tbl.push_back(mk(1'b1, 2'b00, A0, Z, A0, Z, 2'b11, 5'd4, 5'd4, 1'b0, A0, Z, Z, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b11, 5'd4, 5'd9, 1'b0, A0, Z, Z, 2'b00, Z, Z, 2'b00));
    // crossed bypass: each read port picks a different write port
    tbl.push_back(mk(1'b0, 2'b11, 5'd10, 32'h10, 5'd11, 32'h11, 2'b11, 5'd11, 5'd10, 1'b0, A0, 32'h11, 32'h10, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b11, 5'd10, 5'd11, 1'b0, A0, 32'h10, 32'h11, 2'b00, 32'h10, 32'h11, 2'b00));
    // top address, full-width data
    tbl.push_back(mk(1'b0, 2'b10, A0, Z, 5'd31, 32'hFFFF_FFFF, 2'b00, A0, A0, 1'b0, A0, Z, Z, 2'b00, Z, Z, 2'b00));
    tbl.push_back(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b01, 5'd31, A0, 1'b0, A0, 32'hFFFF_FFFF, Z, 2'b00, 32'hFFFF_FFFF, Z, 2'b00));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // busy bit persists across idle cycles until a write retires it
    step(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b00, A0, A0, 1'b1, 5'd12, Z, Z, 2'b00, Z, Z, 2'b00), 100);
    for (int i = 0; i < 3; i++)
      step(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b01, 5'd12, A0, 1'b0, A0, Z, Z, 2'b01, Z, Z, 2'b01), 101 + i);
    step(mk(1'b0, 2'b01, 5'd12, 32'hC, A0, Z, 2'b10, A0, 5'd12, 1'b0, A0, Z, 32'hC, 2'b00, Z, Z, 2'b10), 104);
    step(mk(1'b0, 2'b00, A0, Z, A0, Z, 2'b01, 5'd12, A0, 1'b0, A0, 32'hC, Z, 2'b00, 32'hC, Z, 2'b00), 105);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
